nibble_serial_add_ctrl: RTL and testbench

Sequencer that adds wide operands (4*NIBBLES bits) over several cycles using a single shared 4-bit ripple adder slice. It processes one nibble per cycle, least-significant first, and keeps the carry in a register between nibbles. It is the area-lean arithmetic path for wide counters and accumulators in the datapath. It uses a valid/ready handshake on both the request side and the result side.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 17 +
 rtl/nibble_serial_add_ctrl_add_slice.sv | 26 ++
 rtl/nibble_serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encodings and slice width live here.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_add_slice.sv
// Combinational 4-bit ripple adder slice made of full-adder cells.
// Shared by every nibble step of the serial adder.
module nibble_add_slice
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_c,
  output logic [NIBBLE_W-1:0] o_s,
  output logic                o_c
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = i_c;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    logic w_p;
    assign w_p      = i_a[i] ^ i_b[i];
    assign o_s[i]   = w_p ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & w_p);
  end

  assign o_c = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder sequenced one nibble per cycle through a shared slice.
// Define NIBBLE_SUB_EN to add the op port (op=1 computes a-b).
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef NIBBLE_SUB_EN
  input  logic         op,
`endif
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int IW = idx_w(NIBBLES);

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [IW-1:0] r_idx;

  logic [IW+1:0]         w_base;
  logic [NIBBLE_W-1:0]   w_a_nib;
  logic [NIBBLE_W-1:0]   w_b_nib;
  logic [NIBBLE_W-1:0]   w_s_nib;
  logic                  w_co;
  logic                  w_last;
  logic [W-1:0]          w_b_cap;
  logic                  w_c_cap;

  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: NIBBLE_W];
  assign w_b_nib = r_b[w_base +: NIBBLE_W];
  assign w_last  = (r_idx == IW'(NIBBLES - 1));

  // Subtraction is a + ~b + 1, so only the captured operands differ.
`ifdef NIBBLE_SUB_EN
  assign w_b_cap = op ? ~b : b;
  assign w_c_cap = op ? 1'b1 : cin;
`else
  assign w_b_cap = b;
  assign w_c_cap = cin;
`endif

  nibble_add_slice u_slice (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .i_c (r_carry),
    .o_s (w_s_nib),
    .o_c (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a     <= a;
            r_b     <= w_b_cap;
            r_carry <= w_c_cap;
            r_sum   <= '0;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: NIBBLE_W] <= w_s_nib;
          r_carry <= w_co;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout  <= w_co;
            r_idx   <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready  = (r_state == IDLE);
  assign result_valid = (r_state == DONE);
  assign busy         = (r_state == RUN) || (r_state == DONE);
  assign sum          = r_sum;
  assign cout         = r_cout;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (NIBBLES=4).
// Build with NIBBLE_SUB_EN defined to also exercise subtraction.
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  res_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
`ifdef NIBBLE_SUB_EN
    .op           (op),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic c, input logic o);
    logic [W:0] t;
    if (o) t = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return '{s: t[W-1:0], c: t[W]};
  endfunction

  // Push on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (start_valid && start_ready)
        sb.push_back(model(a, b, cin, op));
      if (result_valid && result_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic top,
                        input int hold, input bit pulse);
    res_t e;
    int   lat;
    e = model(ta, tb_, tc, top);
    @(posedge clk); #1;
    a = ta; b = tb_; cin = tc; op = top;
    start_valid = 1'b1; result_ready = 1'b0;
    @(negedge clk);
    chk("start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    if (pulse) begin
      a = ~ta; b = ~tb_;
      @(negedge clk);
      chk("run_ready", 32'(start_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd1);
    end else begin
      start_valid = 1'b0;
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat++;
      @(negedge clk);
      if (result_valid) break;
    end
    chk("latency", 32'(lat), 32'(N));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_sum", 32'(sum), 32'(e.s));
      chk("hold_cout", 32'(cout), 32'(e.c));
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_ready", 32'(start_ready), 32'd0);
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(start_ready), 32'd1);
    chk("idle_valid", 32'(result_valid), 32'd0);
  endtask

  logic [W-1:0] ta_tab [4] = '{16'h0001, 16'h8000, 16'hABCD, 16'hFFFF};
  logic [W-1:0] tb_tab [4] = '{16'h0002, 16'h8000, 16'h1111, 16'hFFFF};

  initial begin
    int w;
    int tprev;
    int tcur;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h9876, 16'h6789, 1'b1, 1'b0, 5, 1'b1);

    // Abort a run with reset after two RUN edges.
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; op = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_ready", 32'(start_ready), 32'd1);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom),
             1'b0, int'($urandom_range(0, 2)), 1'b0);
    end

    // Back-to-back with both handshakes held high.
    @(posedge clk); #1;
    result_ready = 1'b1;
    a = ta_tab[0]; b = tb_tab[0]; cin = 1'b0; op = 1'b0;
    start_valid = 1'b1;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      @(negedge clk);
      while (!start_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("b2b_wait", 32'(w < 20), 32'd1);
      @(posedge clk); #1;
      tcur = cyc;
      if (k > 0) chk("b2b_gap", 32'(tcur - tprev), 32'(N + 2));
      tprev = tcur;
      if (k < 3) begin
        a = ta_tab[k+1]; b = tb_tab[k+1]; cin = 1'(k);
      end else begin
        start_valid = 1'b0;
      end
    end
    w = 0;
    while (sb.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    result_ready = 1'b0;

`ifdef NIBBLE_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h1234, 16'h0101, 1'b1, 1'b0, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
